// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle for counter_seq_ctrl.
// The master side drives run/mode/step; the slave side returns count, LEDs and strobes.
interface counter_seq_ctrl_if;
  logic       en;
  logic [1:0] mode;
  logic       step_req;
  logic       step_ack;
  logic       tick;
  logic [2:0] q;
  logic [7:0] led;
  logic       wrap;

  modport master (
    output en, mode, step_req,
    input  step_ack, tick, q, led, wrap
  );

  modport slave (
    input  en, mode, step_req,
    output step_ack, tick, q, led, wrap
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// 3-bit LED count sequencer: prescaled free-run or single-step advance in up/down/Gray/hold modes.
// Optional build macro CNT_SEQ_GRAY_EN enables the Gray-coded display in mode 10.
module counter_seq_ctrl #(
  parameter int unsigned     DIV_W   = 24,
  parameter logic [DIV_W-1:0] DIV_MAX = DIV_W'(24'd9_999_999)
) (
  input logic               clk,
  input logic               clr,
  counter_seq_ctrl_if.slave bus
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic [2:0]       cnt;
  logic [2:0]       cnt_nxt;
  logic [2:0]       q_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             ack_r;
  logic [2:0]       q_r;
  logic [7:0]       led_r;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             tick_c;
  logic             adv;
  logic             upd;

  // Terminal count is suppressed while paused or in reset.
  assign tick_c = bus.en & ~clr & (div_cnt == DIV_MAX);

  // Run path owns the advance while enabled; otherwise a fresh step request does.
  assign adv = bus.en ? tick_c : (bus.step_req & ~ack_r);
  assign upd = adv & (bus.mode != MODE_HOLD);

  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    case (bus.mode)
      MODE_UP, MODE_GRAY: begin
        cnt_nxt  = cnt + 3'd1;
        wrap_nxt = (cnt == 3'd7);
      end
      MODE_DOWN: begin
        cnt_nxt  = cnt - 3'd1;
        wrap_nxt = (cnt == 3'd0);
      end
      default: begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    q_nxt = cnt_nxt;
`ifdef CNT_SEQ_GRAY_EN
    if (bus.mode == MODE_GRAY) q_nxt = cnt_nxt ^ (cnt_nxt >> 1);
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt     <= 3'd0;
      div_cnt <= '0;
      ack_r   <= 1'b0;
      q_r     <= 3'd0;
      led_r   <= 8'h01;
      wrap_r  <= 1'b0;
    end else begin
      if (!bus.en)     div_cnt <= '0;
      else if (tick_c) div_cnt <= '0;
      else             div_cnt <= div_cnt + DIV_W'(1);

      // Four-phase acknowledge: set with the advance, cleared once the request drops.
      if (bus.en)            ack_r <= 1'b0;
      else if (!bus.step_req) ack_r <= 1'b0;
      else if (!ack_r)       ack_r <= 1'b1;

      wrap_r <= 1'b0;
      if (upd) begin
        cnt    <= cnt_nxt;
        q_r    <= q_nxt;
        led_r  <= 8'd1 << q_nxt;
        wrap_r <= wrap_nxt;
      end
    end
  end

  assign bus.tick     = tick_c;
  assign bus.step_ack = ack_r;
  assign bus.q        = q_r;
  assign bus.led      = led_r;
  assign bus.wrap     = wrap_r;

endmodule
